// File: rtl/prpg_pkg.sv
// Shared definitions for the 3-bit PRPG checker: FSM state encodings,
// the generator tap mask for x^3+x^2+1, and the next-word function.
package prpg_pkg;

  // state | meaning
  // HUNT  | waiting for a nonzero word to seed the expected sequence
  // SYNC  | counting consecutive matches toward lock
  // LOCKED| synchronised; mismatches are reported as errors
  // BAD   | unused encoding, returns to HUNT on the next clock
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_BAD    = 2'd3
  } state_t;

  // Feedback taps for x^3+x^2+1: bits 3 and 2 of the [3:1] word.
  localparam logic [3:1] PRPG_TAPS  = 3'b110;
  localparam logic [3:1] PRPG_ZERO  = 3'b000;
  localparam logic [3:1] PRPG_START = 3'b001;

  // Shift left by one and insert the tap parity at bit 1.
  function automatic logic [3:1] prpg_next(input logic [3:1] p);
    prpg_next = {p[2:1], ^(p & PRPG_TAPS)};
  endfunction

endpackage

// File: rtl/prpg_3bit_next.sv
// Combinational next-word generator for the 3-bit PRPG.
module prpg_3bit_next
  import prpg_pkg::*;
(
  input  logic [3:1] cur,
  output logic [3:1] nxt
);

  assign nxt = prpg_next(cur);

endmodule

// File: rtl/prpg_3bit_checker.sv
// 3-bit PRPG sequence checker: acquires lock on x^3+x^2+1 words, then
// counts mismatches. Optional macro PRPG_CHK_PERIOD_EN adds a 'period'
// output that pulses when a matching locked word equals 001.
module prpg_3bit_checker
  import prpg_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             p_valid,
  input  logic [3:1]       p_input,
  output logic             lock,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
`ifdef PRPG_CHK_PERIOD_EN
  output logic             period,
`endif
  output logic [1:0]       state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  state_t           state_q, state_d;
  logic [3:1]       exp_q, exp_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    loss_q, loss_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PRPG_CHK_PERIOD_EN
  logic             period_q, period_d;
`endif

  logic [3:1] exp_adv;
  logic [3:1] seed;

  // Advance of the tracked expected word, and seed from the received word.
  prpg_3bit_next u_next_exp (.cur(exp_q),   .nxt(exp_adv));
  prpg_3bit_next u_next_in  (.cur(p_input), .nxt(seed));

  // State and output registers; all outputs come straight from here.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_HUNT;
      exp_q    <= PRPG_ZERO;
      match_q  <= '0;
      loss_q   <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef PRPG_CHK_PERIOD_EN
      period_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      loss_q   <= loss_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`ifdef PRPG_CHK_PERIOD_EN
      period_q <= period_d;
`endif
    end
  end

  // Next-state and next-output logic; invalid cycles hold everything.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    match_d  = match_q;
    loss_d   = loss_q;
    lock_d   = lock_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
`ifdef PRPG_CHK_PERIOD_EN
    period_d = 1'b0;
`endif
    case (state_q)
      ST_HUNT: begin
        lock_d = 1'b0;
        if (p_valid && (p_input != PRPG_ZERO)) begin
          exp_d   = seed;
          match_d = '0;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (p_valid) begin
          if (p_input == exp_q) begin
            exp_d   = exp_adv;
            match_d = match_q + MW'(1);
            if ((match_q + MW'(1)) == MW'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              lock_d  = 1'b1;
              loss_d  = '0;
              match_d = '0;
            end
          end else if (p_input != PRPG_ZERO) begin
            exp_d   = seed;
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = ST_HUNT;
          end
        end
      end
      ST_LOCKED: begin
        if (p_valid) begin
          // Locked tracking free-runs; received data never reseeds it.
          exp_d = exp_adv;
          if (p_input == exp_q) begin
            loss_d = '0;
`ifdef PRPG_CHK_PERIOD_EN
            period_d = (p_input == PRPG_START);
`endif
          end else begin
            err_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if ((loss_q + LW'(1)) == LW'(LOSS_CNT)) begin
              loss_d  = '0;
              lock_d  = 1'b0;
              state_d = ST_HUNT;
            end else begin
              loss_d = loss_q + LW'(1);
            end
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
        lock_d  = 1'b0;
        match_d = '0;
        loss_d  = '0;
      end
    endcase
  end

  assign state   = state_q;
  assign lock    = lock_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;
`ifdef PRPG_CHK_PERIOD_EN
  assign period  = period_q;
`endif

endmodule

// File: tb/tb_prpg_3bit_checker.sv
// Directed bench for prpg_3bit_checker with a sequence-position model.
// Two DUTs share stimulus: default widths, and CNT_W=2 for saturation.
module tb_prpg_3bit_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       p_valid = 1'b0;
  logic [2:0] p_input = 3'b000;

  logic       lock, err, lock2, err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [1:0] state, state2;
`ifdef PRPG_CHK_PERIOD_EN
  logic       period, period2;
`endif

  prpg_3bit_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .p_valid(p_valid), .p_input(p_input),
    .lock(lock), .err(err), .err_cnt(err_cnt),
`ifdef PRPG_CHK_PERIOD_EN
    .period(period),
`endif
    .state(state)
  );

  prpg_3bit_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .p_valid(p_valid), .p_input(p_input),
    .lock(lock2), .err(err2), .err_cnt(err_cnt2),
`ifdef PRPG_CHK_PERIOD_EN
    .period(period2),
`endif
    .state(state2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Model: the sequence as a table, expected word kept as a table position.
  int seq[7] = '{1, 2, 5, 3, 7, 6, 4};
  int m_mode = 0;      // 0 hunt, 1 sync, 2 locked
  int m_pos = 0;
  int m_matches = 0;
  int m_misses = 0;
  int m_errs = 0;
  int m_err = 0;
  int m_period = 0;

  function automatic int pos_of(input int w);
    for (int i = 0; i < 7; i++) if (seq[i] == w) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_mode = 0; m_pos = 0; m_matches = 0; m_misses = 0;
      m_errs = 0; m_err = 0; m_period = 0;
    end else begin
      int w;
      w = int'(p_input);
      m_err = 0;
      m_period = 0;
      if (p_valid) begin
        if (m_mode == 0) begin
          if (w != 0) begin m_pos = (pos_of(w) + 1) % 7; m_matches = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
          if (w == seq[m_pos]) begin
            m_pos = (m_pos + 1) % 7;
            m_matches++;
            if (m_matches == LOCK_CNT) begin m_mode = 2; m_misses = 0; end
          end else if (w != 0) begin
            m_pos = (pos_of(w) + 1) % 7; m_matches = 0;
          end else begin
            m_mode = 0;
          end
        end else begin
          if (w == seq[m_pos]) begin
            m_misses = 0;
            if (w == 1) m_period = 1;
          end else begin
            m_err = 1; m_errs++; m_misses++;
            if (m_misses == LOSS_CNT) m_mode = 0;
          end
          m_pos = (m_pos + 1) % 7;
        end
      end
    end
  end

  // Compare process: outputs settle after the rising edge, sampled on the falling one.
  always @(negedge clk) begin
    chk("state", int'(state), m_mode);
    chk("lock", int'(lock), (m_mode == 2) ? 1 : 0);
    chk("err", int'(err), m_err);
    chk("err_cnt", int'(err_cnt), (m_errs > 255) ? 255 : m_errs);
    chk("err_cnt_w2", int'(err_cnt2), (m_errs > 3) ? 3 : m_errs);
    chk("state_w2", int'(state2), m_mode);
`ifdef PRPG_CHK_PERIOD_EN
    chk("period", int'(period), m_period);
`endif
  end

  int gpos = 0;

  task automatic step(input logic v, input logic [2:0] w);
    p_valid = v;
    p_input = w;
    @(posedge clk);
    #2;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 3'(seq[gpos]));
      gpos = (gpos + 1) % 7;
    end
  endtask

  task automatic corrupt(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 3'b000);
      gpos = (gpos + 1) % 7;
    end
  endtask

  task automatic pulse_reset();
    clr = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    @(posedge clk);
    #2;
    clr = 1'b1;
  endtask

  initial begin
    #1 clr = 1'b0;
    #1;
    chk("por_state", int'(state), 0);
    chk("por_lock", int'(lock), 0);
    chk("por_err", int'(err), 0);
    chk("por_err_cnt", int'(err_cnt), 0);
    repeat (2) @(posedge clk);
    #2 clr = 1'b1;

    // All-zero stream never leaves HUNT.
    for (int i = 0; i < 10; i++) step(1'b1, 3'b000);
    chk("zeros_state", int'(state), 0);
    chk("zeros_lock", int'(lock), 0);

    // SYNC mismatch reseeds from a nonzero word, drops to HUNT on 000.
    step(1'b1, 3'b001);
    step(1'b1, 3'b010);
    step(1'b1, 3'b111);
    chk("sync_reseed_state", int'(state), 1);
    step(1'b1, 3'b000);
    chk("sync_zero_state", int'(state), 0);
    step(1'b1, 3'b011);
    step(1'b1, 3'b111);
    step(1'b1, 3'b110);
    step(1'b1, 3'b100);
    chk("sync_pre_lock", int'(lock), 0);
    step(1'b1, 3'b001);
    chk("sync_relock", int'(lock), 1);
    chk("sync_err_cnt", int'(err_cnt), 0);

    // Clean stream from 001 locks on the fifth word.
    pulse_reset();
    gpos = 0;
    clean(4);
    chk("clean_lock4", int'(lock), 0);
    clean(1);
    chk("clean_lock5", int'(lock), 1);
    chk("clean_state5", int'(state), 2);
    clean(45);
    chk("clean50_err_cnt", int'(err_cnt), 0);

    // Single corrupted word: 110 replaced with 000.
    while (seq[gpos] != 6) clean(1);
    corrupt(1);
    chk("one_err", int'(err), 1);
    chk("one_err_cnt", int'(err_cnt), 1);
    chk("one_lock", int'(lock), 1);
    clean(1);
    chk("one_after_err", int'(err), 0);

    // Three corrupted words in a row drop lock.
    clean(3);
    corrupt(2);
    chk("three_lock_held", int'(lock), 1);
    corrupt(1);
    chk("three_err_cnt", int'(err_cnt), 4);
    chk("three_lock", int'(lock), 0);
    chk("three_state", int'(state), 0);
    clean(4);
    chk("relock4", int'(lock), 0);
    clean(1);
    chk("relock5", int'(lock), 1);

    // Alternating valid/invalid with garbage on idle cycles.
    for (int i = 0; i < 10; i++) begin
      clean(1);
      step(1'b0, 3'b101);
      chk("idle_err", int'(err), 0);
    end
    chk("toggle_err_cnt", int'(err_cnt), 4);

    // Reset in the middle of a locked stream.
    clean(2);
    pulse_reset();
    chk("mid_rst_w2", int'(err_cnt2), 0);
    clean(4);
    chk("mid_relock4", int'(lock), 0);
    clean(1);
    chk("mid_relock5", int'(lock), 1);

    // Repeated loss and re-lock drives the narrow counter to saturation.
    for (int r = 0; r < 2; r++) begin
      corrupt(3);
      clean(5);
    end
    chk("sat_w2", int'(err_cnt2), 3);
    chk("sat_w8", int'(err_cnt), 6);
    clean(21);

    step(1'b0, 3'b000);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prpg_3bit_checker.md
PRPG_3BIT_CHECKER -- requirements
Module: prpg_3bit_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive matches needed to declare lock.
REQ-002 SHALL have parameter LOSS_CNT, default 3: consecutive mismatches in LOCKED that drop lock.
REQ-003 SHALL have parameter CNT_W, default 8: error counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port clr  input  1  reset: asynchronous, active-low.
REQ-006 SHALL have port p_valid  input  1  p_input holds a pattern word this cycle.
REQ-007 SHALL have port p_input  input  [3:1]  received PRPG word.
REQ-008 SHALL have port lock  output  1  checker synchronised to the sequence.
REQ-009 SHALL have port err  output  1  one-cycle pulse per mismatched word while LOCKED.
REQ-010 SHALL have port err_cnt  output  [CNT_W-1:0]  saturating mismatch count.
REQ-011 SHALL have port state  output  [1:0]  current FSM state encoding.

Function
REQ-012 SHALL model the generator polynomial x^3+x^2+1: next = {p[2], p[1], p[3]^p[2]}, period 7 (001,010,101,011,111,110,100).
REQ-013 SHALL act only on cycles with p_valid=1; with p_valid=0, all state, counters and expected word hold, and err=0.
REQ-014 SHALL implement states HUNT=0, SYNC=1, LOCKED=2; encoding 3 unused, recovers to HUNT next cycle.
REQ-015 HUNT: nonzero valid word -> load expected=next(p_input), match count=0, go SYNC; word 000 -> stay HUNT.
REQ-016 SYNC: p_input==expected -> match count+1, expected=next(expected); on reaching LOCK_CNT -> LOCKED, lock=1.
REQ-017 SYNC: mismatch -> reseed from p_input as in HUNT (SYNC if nonzero, HUNT if 000); no err, err_cnt unchanged.
REQ-018 LOCKED: expected=next(expected) every valid word regardless of match (no reseed from data).
REQ-019 LOCKED mismatch -> err=1 next cycle, err_cnt+1 saturating at all-ones, loss count+1; match -> loss count=0.
REQ-020 LOCKED: loss count reaching LOSS_CNT -> HUNT, lock=0 next cycle; that mismatch still counts in err/err_cnt.
REQ-021 All outputs SHALL be registered; err, lock and state reflect a word one clock after it is sampled.
REQ-022 err_cnt SHALL be cleared only by reset; it holds through lock loss and re-lock.

Reset
REQ-023 clr=0 SHALL immediately force state=HUNT, lock=0, err=0, err_cnt=0, expected=000, internal counts=0.
REQ-024 Reset mid-sequence SHALL discard lock; after release, re-acquisition needs 1+LOCK_CNT valid words.

Configuration
REQ-025 Macro PRPG_CHK_PERIOD_EN defined: extra output period (1 bit) pulses one cycle when a matching LOCKED word equals 001; reset 0.
REQ-026 Macro undefined: no period port, no related logic.

Structure
REQ-027 Shared package prpg_pkg SHALL hold the state encodings, the polynomial tap constant and the next-state function.
REQ-028 Sub-module prpg_3bit_next (combinational next-word generator) SHALL be instantiated for expected-word advance.

Verification
REQ-029 Clean stream from 001, p_valid=1 each cycle -> lock=1 after 5th word registers; err_cnt stays 0 for 50 words.
REQ-030 Locked, one word corrupted (110 replaced by 000) -> single err pulse, err_cnt=1, lock stays 1, next word matches.
REQ-031 Locked, 3 consecutive corrupted words -> err_cnt=+3, lock=0 and state=HUNT after third; clean words re-lock after 5 more.
REQ-032 Stream of 000 words from reset -> state remains HUNT, lock=0, err=0.
REQ-033 Locked, p_valid toggled 1/0 alternately -> no false errors; clr pulsed low mid-stream -> immediate HUNT, err_cnt=0.
REQ-034 CNT_W=2, continuous errors with relocks -> err_cnt saturates at 3; with PRPG_CHK_PERIOD_EN, period pulses every 7 locked words.
